// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue
//   Small FIFO between instruction fetch and decode. Fetch pushes an
//   instruction/PC pair with a valid/ready handshake; decode pops the head
//   entry with its own valid/ready handshake. The queue can be frozen (hold)
//   or emptied (flush, e.g. on a taken branch). When empty, the outputs show
//   a NOP instruction and a zero address.
//
// Optional feature (macro IF_ID_BYPASS_EN):
//   When defined, an offered instruction is forwarded combinationally to the
//   outputs while the queue is empty; if decode accepts it in that same cycle
//   it is not written into storage. When undefined, outputs depend only on
//   registered state (minimum latency of one cycle).
//
// Parameters:
//   DW    - instruction width
//   AW    - instruction-address width
//   DEPTH - number of entries (power of two, 2..16)
//   NOP   - instruction presented when no entry is valid
//
// Ports:
//   clk          - clock, rising edge
//   rstn         - synchronous active-low reset
//   flush_i      - discard all entries; overrides hold_i
//   hold_i       - freeze queue (no push, no pop)
//   in_valid_i   - fetch offers inst_i/addr_i
//   in_ready_o   - queue accepts an entry this cycle
//   inst_i       - fetched instruction
//   addr_i       - PC of the fetched instruction
//   out_valid_o  - head entry valid toward decode
//   out_ready_i  - decode consumes the head entry
//   inst_o       - head instruction (NOP when not valid)
//   addr_o       - head PC (zero when not valid)
//   count_o      - current occupancy
// ----------------------------------------------------------------------------
module if_id_queue #(
    parameter int unsigned   DW    = 32,
    parameter int unsigned   AW    = 32,
    parameter int unsigned   DEPTH = 2,
    parameter logic [DW-1:0] NOP   = DW'(32'h00000013)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush_i,
    input  logic                         hold_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DW-1:0]                inst_i,
    input  logic [AW-1:0]                addr_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DW-1:0]                inst_o,
    output logic [AW-1:0]                addr_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [DW-1:0] inst_mem_q [DEPTH];
    logic [DW-1:0] inst_mem_d [DEPTH];
    logic [AW-1:0] addr_mem_q [DEPTH];
    logic [AW-1:0] addr_mem_d [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    logic q_valid;
    logic q_pop;
    logic push;
    logic store;
    logic bypass;

    // Handshake decode
    always_comb begin
        q_valid    = (count_q != '0);
        q_pop      = q_valid & out_ready_i & ~hold_i;
        // A pop in the same cycle frees a slot, so a full queue still accepts.
        in_ready_o = rstn & ~hold_i & ~flush_i &
                     ((count_q < CW'(DEPTH)) | q_pop);
        push       = in_valid_i & in_ready_o;
`ifdef IF_ID_BYPASS_EN
        bypass     = rstn & ~q_valid & in_valid_i & ~hold_i & ~flush_i;
        // A forwarded entry taken by decode this cycle never enters storage.
        store      = push & ~(bypass & out_ready_i);
`else
        bypass     = 1'b0;
        store      = push;
`endif
    end

    // Next-state: pointers, occupancy and storage
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        inst_mem_d = inst_mem_q;
        addr_mem_d = addr_mem_q;

        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (store) begin
                inst_mem_d[wptr_q] = inst_i;
                addr_mem_d[wptr_q] = addr_i;
                wptr_d             = wptr_q + PW'(1);
            end
            if (q_pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({store, q_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; its contents are masked by out_valid_o.
    always_ff @(posedge clk) begin
        inst_mem_q <= inst_mem_d;
        addr_mem_q <= addr_mem_d;
    end

    // Outputs
    always_comb begin
        count_o     = count_q;
        out_valid_o = q_valid;
        inst_o      = NOP;
        addr_o      = '0;
        if (q_valid) begin
            inst_o = inst_mem_q[rptr_q];
            addr_o = addr_mem_q[rptr_q];
        end else if (bypass) begin
            out_valid_o = 1'b1;
            inst_o      = inst_i;
            addr_o      = addr_i;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// ----------------------------------------------------------------------------
// tb_if_id_queue
//   Self-checking bench for if_id_queue (DEPTH = 2, DW = AW = 32). Directed
//   scenarios use literal expected values; a randomized run compares every
//   output against a queue-based reference model. Honours IF_ID_BYPASS_EN.
// ----------------------------------------------------------------------------
module tb_if_id_queue;

    localparam int unsigned   DW    = 32;
    localparam int unsigned   AW    = 32;
    localparam int unsigned   DEPTH = 2;
    localparam logic [31:0]   NOP   = 32'h00000013;

    logic          clk;
    logic          rstn;
    logic          flush_i;
    logic          hold_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] inst_i;
    logic [AW-1:0] addr_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] inst_o;
    logic [AW-1:0] addr_o;
    logic [1:0]    count_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
    } ent_t;

    if_id_queue #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH),
        .NOP   (NOP)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (flush_i),
        .hold_i      (hold_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .inst_i      (inst_i),
        .addr_i      (addr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .inst_o      (inst_o),
        .addr_o      (addr_o),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change #1 after it.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_i     = 1'b0;
        hold_i      = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        inst_i      = '0;
        addr_i      = '0;
    endtask

    // Empty the queue with one flush cycle.
    task automatic drain();
        idle();
        flush_i = 1'b1;
        next();
        flush_i = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] inst, input logic [31:0] addr);
        in_valid_i = 1'b1;
        inst_i     = inst;
        addr_i     = addr;
        next();
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rstn       = 1'b0;
        in_valid_i = 1'b1;
        inst_i     = 32'hdeadbeef;
        addr_i     = 32'h00001000;
        next();
        @(negedge clk);
        total_cnt++;
        if (in_ready_o !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready_o);
        else pass_cnt++;
        next();
        idle();
        rstn = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (inst_o !== NOP) $display("FAIL reset_inst: got %h expected %h", inst_o, NOP);
        else pass_cnt++;
        total_cnt++;
        if (addr_o !== 32'h0) $display("FAIL reset_addr: got %h expected 0", addr_o);
        else pass_cnt++;
        total_cnt++;
        if (count_o !== 2'd0) $display("FAIL reset_count: got %0d expected 0", count_o);
        else pass_cnt++;
        // Reset with entries present drops them.
        next();
        push_one(32'h11111111, 32'h100);
        push_one(32'h22222222, 32'h104);
        rstn = 1'b0;
        next();
        rstn = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (count_o !== 2'd0 || out_valid_o !== 1'b0)
            $display("FAIL reset_midflight: got count %0d valid %b expected 0 0", count_o, out_valid_o);
        else pass_cnt++;
        next();
    endtask

    task automatic test_single();
        drain();
        in_valid_i  = 1'b1;
        inst_i      = 32'h00500093;
        addr_i      = 32'h80000000;
`ifdef IF_ID_BYPASS_EN
        out_ready_i = 1'b0;
`else
        out_ready_i = 1'b1;
`endif
        next();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_valid_o !== 1'b1) $display("FAIL single_valid: got %b expected 1", out_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (inst_o !== 32'h00500093) $display("FAIL single_inst: got %h expected 00500093", inst_o);
        else pass_cnt++;
        total_cnt++;
        if (addr_o !== 32'h80000000) $display("FAIL single_addr: got %h expected 80000000", addr_o);
        else pass_cnt++;
        next();
        @(negedge clk);
        total_cnt++;
        if (inst_o !== NOP || addr_o !== 32'h0 || out_valid_o !== 1'b0)
            $display("FAIL single_after: got inst %h addr %h valid %b expected %h 0 0",
                     inst_o, addr_o, out_valid_o, NOP);
        else pass_cnt++;
        next();
        idle();
    endtask

    task automatic test_fill();
        logic [31:0] vals [3];
        vals[0] = 32'haaaa0001;
        vals[1] = 32'hbbbb0002;
        vals[2] = 32'hcccc0003;
        drain();
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            inst_i     = vals[i];
            addr_i     = 32'h200 + 32'(i * 4);
            @(negedge clk);
            total_cnt++;
            if (in_ready_o !== (i < 2 ? 1'b1 : 1'b0))
                $display("FAIL fill_ready_%0d: got %b expected %b", i, in_ready_o, (i < 2));
            else pass_cnt++;
            next();
        end
        in_valid_i = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (count_o !== 2'd2) $display("FAIL fill_count: got %0d expected 2", count_o);
        else pass_cnt++;
        total_cnt++;
        if (inst_o !== vals[0] || addr_o !== 32'h200)
            $display("FAIL fill_head0: got %h/%h expected %h/200", inst_o, addr_o, vals[0]);
        else pass_cnt++;
        out_ready_i = 1'b1;
        next();
        @(negedge clk);
        total_cnt++;
        if (inst_o !== vals[1] || addr_o !== 32'h204 || count_o !== 2'd1)
            $display("FAIL fill_head1: got %h/%h cnt %0d expected %h/204 cnt 1",
                     inst_o, addr_o, count_o, vals[1]);
        else pass_cnt++;
        next();
        @(negedge clk);
        total_cnt++;
        if (count_o !== 2'd0 || out_valid_o !== 1'b0)
            $display("FAIL fill_empty: got cnt %0d valid %b expected 0 0", count_o, out_valid_o);
        else pass_cnt++;
        idle();
        next();
    endtask

    task automatic test_full_push_pop();
        drain();
        push_one(32'h0000a0a0, 32'h300);
        push_one(32'h0000b1b1, 32'h304);
        in_valid_i  = 1'b1;
        inst_i      = 32'h0000c2c2;
        addr_i      = 32'h308;
        out_ready_i = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (in_ready_o !== 1'b1) $display("FAIL fullpp_ready: got %b expected 1", in_ready_o);
        else pass_cnt++;
        next();
        in_valid_i = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (count_o !== 2'd2 || inst_o !== 32'h0000b1b1)
            $display("FAIL fullpp_count: got cnt %0d inst %h expected 2 0000b1b1", count_o, inst_o);
        else pass_cnt++;
        next();
        @(negedge clk);
        total_cnt++;
        if (inst_o !== 32'h0000c2c2 || addr_o !== 32'h308 || count_o !== 2'd1)
            $display("FAIL fullpp_newest: got %h/%h cnt %0d expected 0000c2c2/308 cnt 1",
                     inst_o, addr_o, count_o);
        else pass_cnt++;
        next();
        idle();
    endtask

    task automatic test_flush_hold();
        drain();
        push_one(32'h12340001, 32'h400);
        push_one(32'h12340002, 32'h404);
        flush_i     = 1'b1;
        hold_i      = 1'b1;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        inst_i      = 32'h55555555;
        @(negedge clk);
        total_cnt++;
        if (in_ready_o !== 1'b0) $display("FAIL flush_ready: got %b expected 0", in_ready_o);
        else pass_cnt++;
        next();
        idle();
        @(negedge clk);
        total_cnt++;
        if (count_o !== 2'd0 || inst_o !== NOP || out_valid_o !== 1'b0)
            $display("FAIL flush_empty: got cnt %0d inst %h valid %b expected 0 %h 0",
                     count_o, inst_o, out_valid_o, NOP);
        else pass_cnt++;
        next();
    endtask

    task automatic test_hold();
        drain();
        push_one(32'h0abc0def, 32'h500);
        hold_i      = 1'b1;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        inst_i      = 32'h99999999;
        addr_i      = 32'h900;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if (count_o !== 2'd1 || inst_o !== 32'h0abc0def || addr_o !== 32'h500 || in_ready_o !== 1'b0)
                $display("FAIL hold_cycle_%0d: got cnt %0d %h/%h rdy %b expected 1 0abc0def/500 0",
                         i, count_o, inst_o, addr_o, in_ready_o);
            else pass_cnt++;
            next();
        end
        hold_i     = 1'b0;
        in_valid_i = 1'b0;
        next();
        @(negedge clk);
        total_cnt++;
        if (count_o !== 2'd0) $display("FAIL hold_release: got %0d expected 0", count_o);
        else pass_cnt++;
        idle();
        next();
    endtask

    task automatic test_bypass();
        drain();
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        inst_i      = 32'h00000033;
        addr_i      = 32'h600;
        @(negedge clk);
`ifdef IF_ID_BYPASS_EN
        total_cnt++;
        if (inst_o !== 32'h00000033 || out_valid_o !== 1'b1 || count_o !== 2'd0)
            $display("FAIL bypass_fwd: got %h valid %b cnt %0d expected 00000033 1 0",
                     inst_o, out_valid_o, count_o);
        else pass_cnt++;
`else
        total_cnt++;
        if (inst_o !== NOP || out_valid_o !== 1'b0)
            $display("FAIL bypass_none: got %h valid %b expected %h 0", inst_o, out_valid_o, NOP);
        else pass_cnt++;
`endif
        next();
        in_valid_i = 1'b0;
        @(negedge clk);
`ifdef IF_ID_BYPASS_EN
        total_cnt++;
        if (count_o !== 2'd0) $display("FAIL bypass_nostore: got %0d expected 0", count_o);
        else pass_cnt++;
`else
        total_cnt++;
        if (count_o !== 2'd1 || inst_o !== 32'h00000033)
            $display("FAIL bypass_stored: got cnt %0d inst %h expected 1 00000033", count_o, inst_o);
        else pass_cnt++;
`endif
        next();
        idle();
    endtask

    // Randomized run against a queue model of the queue's documented rules.
    task automatic test_random();
        ent_t        mq[$];
        logic        exp_rdy, exp_vld, byp, pop, push;
        logic [31:0] exp_inst, exp_addr;
        int          errs;
        errs = 0;
        drain();
        mq.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rstn        = ($urandom_range(0, 39) != 0);
            flush_i     = ($urandom_range(0, 15) == 0);
            hold_i      = ($urandom_range(0, 7) == 0);
            in_valid_i  = ($urandom_range(0, 2) != 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            inst_i      = $urandom;
            addr_i      = $urandom;

            exp_rdy = rstn && !hold_i && !flush_i &&
                      (mq.size() < DEPTH || (mq.size() != 0 && out_ready_i));
`ifdef IF_ID_BYPASS_EN
            byp = rstn && mq.size() == 0 && in_valid_i && !hold_i && !flush_i;
`else
            byp = 1'b0;
`endif
            if (mq.size() != 0) begin
                exp_vld = 1'b1; exp_inst = mq[0].inst; exp_addr = mq[0].addr;
            end else if (byp) begin
                exp_vld = 1'b1; exp_inst = inst_i; exp_addr = addr_i;
            end else begin
                exp_vld = 1'b0; exp_inst = NOP; exp_addr = 32'h0;
            end

            @(negedge clk);
            total_cnt++;
            if (in_ready_o !== exp_rdy || out_valid_o !== exp_vld || inst_o !== exp_inst ||
                addr_o !== exp_addr || count_o !== 2'(mq.size())) begin
                if (errs < 10)
                    $display("FAIL random_cyc%0d: got rdy %b vld %b %h/%h cnt %0d expected rdy %b vld %b %h/%h cnt %0d",
                             cyc, in_ready_o, out_valid_o, inst_o, addr_o, count_o,
                             exp_rdy, exp_vld, exp_inst, exp_addr, mq.size());
                errs++;
            end else pass_cnt++;

            @(posedge clk);
            if (!rstn || flush_i) begin
                mq.delete();
            end else if (!hold_i) begin
                pop  = (mq.size() != 0) && out_ready_i;
                push = in_valid_i && exp_rdy && !(byp && out_ready_i);
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back('{inst: inst_i, addr: addr_i});
            end
            #1;
        end
        rstn = 1'b1;
        drain();
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        test_reset();
        test_single();
        test_fill();
        test_full_push_pop();
        test_flush_hold();
        test_hold();
        test_bypass();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DW, default 32, meaning instruction width.
REQ-002 SHALL have parameter AW, default 32, meaning instruction-address width.
REQ-003 SHALL have parameter DEPTH, default 2, meaning entry count (power of two, 2..16).
REQ-004 SHALL have parameter NOP, default 32'h00000013, meaning instruction driven when no valid entry.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rstn  input  1  synchronous active-low reset.
REQ-007 SHALL have port flush_i  input  1  discard all entries (branch/jump taken).
REQ-008 SHALL have port hold_i  input  1  freeze queue (no push, no pop).
REQ-009 SHALL have port in_valid_i  input  1  fetch offers inst_i/addr_i.
REQ-010 SHALL have port in_ready_o  output  1  queue accepts this cycle.
REQ-011 SHALL have ports inst_i  input  DW and addr_i  input  AW  fetched instruction and its PC.
REQ-012 SHALL have port out_valid_o  output  1  head entry valid to decode.
REQ-013 SHALL have port out_ready_i  input  1  decode consumes head.
REQ-014 SHALL have ports inst_o  output  DW and addr_o  output  AW  head instruction and PC.
REQ-015 SHALL have port count_o  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-016 SHALL push when in_valid_i & in_ready_o at a rising edge; pop when out_valid_o & out_ready_i & !hold_i.
REQ-017 SHALL drive in_ready_o = (count_o < DEPTH | pop this cycle) & !hold_i & !flush_i, permitting simultaneous push+pop when full.
REQ-018 SHALL present pushed data on inst_o/addr_o no earlier than the cycle after the push edge (1-cycle latency, registered storage).
REQ-019 SHALL drive inst_o = NOP and addr_o = 0 whenever out_valid_o = 0.
REQ-020 SHALL keep FIFO order; read/write pointers SHALL wrap modulo DEPTH.
REQ-021 SHALL, on flush_i at an edge, set count to 0 and both pointers to 0, ignoring any same-cycle push or pop; flush_i SHALL override hold_i.
REQ-022 SHALL, with hold_i = 1 and flush_i = 0, keep count, pointers and outputs unchanged.
REQ-023 SHALL keep out_valid_o = (count_o != 0), combinational from occupancy.
REQ-024 SHALL leave count unchanged on simultaneous push and pop; never exceed DEPTH nor underflow.

Reset
REQ-025 SHALL, when rstn = 0 at a rising edge, clear count and pointers; next cycle out_valid_o = 0, inst_o = NOP, addr_o = 0, count_o = 0.
REQ-026 SHALL assert in_ready_o = 0 during reset cycles; reset mid-transfer SHALL drop all entries without output.
REQ-027 SHALL not reset storage array contents (data gated by out_valid_o).

Configuration
REQ-028 SHALL, with IF_ID_BYPASS_EN defined, forward inst_i/addr_i combinationally to outputs with out_valid_o = 1 when queue empty, in_valid_i = 1, hold_i = 0, flush_i = 0; if out_ready_i = 1 that cycle, the entry SHALL NOT be stored.
REQ-029 SHALL, without IF_ID_BYPASS_EN, never produce a combinational path from in_valid_i/inst_i/addr_i to any output (minimum latency 1 cycle).

Verification
REQ-030 Bench SHALL check: reset, then push inst 0x00500093 addr 0x80000000, out_ready_i = 1 -> next cycle out_valid_o = 1, inst_o = 0x00500093, addr_o = 0x80000000; following cycle inst_o = NOP, addr_o = 0.
REQ-031 Bench SHALL check: DEPTH = 2, out_ready_i = 0, push 3 back-to-back -> count_o = 2, in_ready_o = 0 on third; after two pops data order first, second.
REQ-032 Bench SHALL check: full queue, push+pop same cycle -> count_o stays 2, new entry appears after older one.
REQ-033 Bench SHALL check: count_o = 2, flush_i = 1 with hold_i = 1 and in_valid_i = 1 -> next cycle count_o = 0, inst_o = NOP.
REQ-034 Bench SHALL check: count_o = 1, hold_i = 1 for 3 cycles with out_ready_i = 1 and in_valid_i = 1 -> count_o = 1, inst_o/addr_o constant.
REQ-035 Bench SHALL check: with IF_ID_BYPASS_EN, empty queue, in_valid_i = 1, out_ready_i = 1, inst_i 0x00000033 -> same cycle inst_o = 0x00000033, count_o stays 0; without macro, inst_o = NOP that cycle.
